// File: rtl/pipelined_carry_lookahead_adder.sv
// Pipelined WIDTH-bit carry-lookahead add/subtract, one BLOCK_WIDTH group resolved per stage, valid/ready on both sides.
// Optional feature: define OVERFLOW_FLAG_EN to add the registered signed-overflow output.
module pipelined_carry_lookahead_adder #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             subtract,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             overflow
`endif
);

    localparam int BW   = (BLOCK_WIDTH > 0) ? BLOCK_WIDTH : 1;
    localparam int NB   = (WIDTH / BW > 0) ? WIDTH / BW : 1;
    localparam int NOPS = (NB > 1) ? NB - 1 : 1;

    if (BLOCK_WIDTH < 1 || WIDTH < BW || (WIDTH % BW) != 0) begin : g_bad_params
        $error("pipelined_carry_lookahead_adder: WIDTH must be a positive multiple of BLOCK_WIDTH");
    end

    // Two-level lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
    function automatic logic [BW:0] group_carries(input logic [BW-1:0] g,
                                                  input logic [BW-1:0] p,
                                                  input logic          cin);
        logic [BW:0] c;
        logic        acc;
        logic        pp;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BW; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
        return c;
    endfunction

    logic [WIDTH-1:0] a_q   [NOPS];
    logic [WIDTH-1:0] b_q   [NOPS];
    logic [WIDTH-1:0] s_q   [NB];
    logic [NB-1:0]    c_q;
    logic [NB-1:0]    v_q;

    logic [WIDTH-1:0] a_src [NB];
    logic [WIDTH-1:0] b_src [NB];
    logic [WIDTH-1:0] s_src [NB];
    logic [WIDTH-1:0] s_nx  [NB];
    logic [NB-1:0]    c_src;
    logic [NB-1:0]    c_nx;
    logic [NB-1:0]    v_src;
    logic [NB-1:0]    en;

    // Stage k may load when it is empty or its contents move on; the chain runs from out_ready back to in_ready.
    always_comb begin : flow
        logic room;
        en          = '0;
        room        = ~v_q[NB-1] | out_ready;
        en[NB-1]    = room;
        for (int k = NB - 2; k >= 0; k--) begin
            room  = ~v_q[k] | room;
            en[k] = room;
        end
    end

    // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
    always_comb begin : stage_logic
        logic [BW-1:0] g;
        logic [BW-1:0] p;
        logic [BW:0]   cy;
        g        = '0;
        p        = '0;
        cy       = '0;
        c_nx     = '0;
        a_src[0] = a;
        b_src[0] = subtract ? ~b : b;
        s_src[0] = '0;
        c_src[0] = carry_in ^ subtract;
        v_src[0] = in_valid;
        for (int k = 1; k < NB; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
            v_src[k] = v_q[k-1];
        end
        for (int k = 0; k < NB; k++) begin
            g                      = a_src[k][k*BW +: BW] & b_src[k][k*BW +: BW];
            p                      = a_src[k][k*BW +: BW] ^ b_src[k][k*BW +: BW];
            cy                     = group_carries(g, p, c_src[k]);
            s_nx[k]                = s_src[k];
            s_nx[k][k*BW +: BW]    = p ^ cy[BW-1:0];
            c_nx[k]                = cy[BW];
        end
    end

    // NOTE: sequential state uses non-blocking '<=' only; rst_n is sampled synchronously.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < NB; k++) s_q[k] <= '0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (en[k]) begin
                    v_q[k] <= v_src[k];
                    if (v_src[k]) begin
                        s_q[k] <= s_nx[k];
                        c_q[k] <= c_nx[k];
                    end
                end
            end
        end
    end

    // NOTE: operand slices carry no reset; a stage ignores them until its valid bit is set.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NB - 1; k++) begin
            if (en[k] && v_src[k]) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
            end
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic ovf_q;
    logic ovf_nx;

    assign ovf_nx = (a_src[NB-1][WIDTH-1] == b_src[NB-1][WIDTH-1]) &
                    (s_nx[NB-1][WIDTH-1] != a_src[NB-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en[NB-1] && v_src[NB-1]) begin
            ovf_q <= ovf_nx;
        end
    end

    assign overflow = ovf_q;
`endif

    assign in_ready  = en[0];
    assign out_valid = v_q[NB-1];
    assign sum       = s_q[NB-1];
    assign carry_out = c_q[NB-1];

endmodule

// File: tb/tb_pipelined_carry_lookahead_adder.sv
// Self-checking bench: directed arithmetic cases, mid-stream reset, backpressure and throughput runs
// against an arithmetic reference model with an in-order expectation queue.
module tb_pipelined_carry_lookahead_adder;

    localparam int WIDTH = 32;
    localparam int BW    = 8;
    localparam int NB    = WIDTH / BW;

    typedef logic [WIDTH+1:0] exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             subtract;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef OVERFLOW_FLAG_EN
    logic             overflow;
`endif

    pipelined_carry_lookahead_adder #(.WIDTH(WIDTH), .BLOCK_WIDTH(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .subtract  (subtract),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef OVERFLOW_FLAG_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   received;
    bit   hold_pending;
    exp_t held;
    bit   in_ready_fell;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the conditioned operands; overflow = true signed result out of range.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic cin, input logic sub);
        logic [WIDTH-1:0] ye;
        logic             c0;
        logic [WIDTH:0]   r;
        longint           sr;
        logic             v;
        ye = sub ? ~y : y;
        c0 = cin ^ sub;
        r  = {1'b0, x} + {1'b0, ye} + {{WIDTH{1'b0}}, c0};
        sr = longint'($signed(x)) + longint'($signed(ye)) + longint'(c0);
        v  = (sr >= (longint'(1) <<< (WIDTH - 1))) || (sr < -(longint'(1) <<< (WIDTH - 1)));
`ifndef OVERFLOW_FLAG_EN
        v  = 1'b0;
`endif
        return {v, r};
    endfunction

    function automatic exp_t observed();
`ifdef OVERFLOW_FLAG_EN
        return {overflow, carry_out, sum};
`else
        return {1'b0, carry_out, sum};
`endif
    endfunction

    task automatic drive_random();
        a        = $urandom;
        b        = $urandom;
        carry_in = 1'($urandom_range(0, 1));
        subtract = 1'($urandom_range(0, 1));
    endtask

    // One clock of streaming: sample settled outputs, score transfers, advance to the next falling edge.
    task automatic cycle(output bit acc);
        #1;
        if (hold_pending) check("stall_hold", {out_valid, observed()}, {1'b1, held});
        hold_pending = out_valid && !out_ready;
        held         = observed();
        if (!in_ready) in_ready_fell = 1'b1;
        acc = in_valid && in_ready;
        if (acc) sb.push_back(model(a, b, carry_in, subtract));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", observed(), e);
            end
            received++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single beat into an empty pipe: latency in edges (accepting edge = 1) and the result.
    task automatic direct(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic cin, input logic sub, input exp_t exp);
        int lat;
        a = x; b = y; carry_in = cin; subtract = sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, NB);
        check(tag, observed(), exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int sent;
        int gaps;
        int stale;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; carry_in = 1'b0; subtract = 1'b0;
        hold_pending = 1'b0; in_ready_fell = 1'b0; received = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry_out", carry_out, 0);
`ifdef OVERFLOW_FLAG_EN
        check("rst_overflow", overflow, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Directed arithmetic; expected words are {overflow, carry_out, sum} from hand calculation.
        direct("ripple_all",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
        direct("sub_5_7",     32'd5,         32'd7,         1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
        direct("sub_7_5",     32'd7,         32'd5,         1'b0, 1'b1, {1'b0, 1'b1, 32'h0000_0002});
        direct("sub_7_5_cin", 32'd7,         32'd5,         1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0001});
`ifdef OVERFLOW_FLAG_EN
        direct("ovf_add_max", 32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        direct("ovf_sub_min", 32'h8000_0000, 32'd1,         1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
`else
        direct("ovf_add_max", 32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, {1'b0, 1'b0, 32'h8000_0000});
        direct("ovf_sub_min", 32'h8000_0000, 32'd1,         1'b0, 1'b1, {1'b0, 1'b1, 32'h7FFF_FFFF});
`endif
        direct("add_1_1",     32'd1,         32'd1,         1'b0, 1'b0, {1'b0, 1'b0, 32'h0000_0002});

        // Reset with three beats in flight: nothing may emerge afterwards.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("midrst_stale", stale, 0);
        @(negedge clk);

        // Backpressure: 10 back-to-back beats, consumer stalled during cycles 3..8.
        sb.delete(); received = 0; sent = 0; hold_pending = 1'b0; in_ready_fell = 1'b0;
        drive_random();
        for (int c = 0; c < 200 && received < 10; c++) begin
            out_ready = !(c >= 3 && c <= 8);
            in_valid  = (sent < 10);
            cycle(acc);
            if (acc) begin
                sent++;
                drive_random();
            end
        end
        check("bp_received", received, 10);
        check("bp_in_ready_fell", in_ready_fell, 1);
        check("bp_queue_empty", sb.size(), 0);

        // Throughput: 1000 beats with no stalls, one result per cycle once the pipe has filled.
        in_valid = 1'b0; out_ready = 1'b1;
        sb.delete(); received = 0; sent = 0; gaps = 0; hold_pending = 1'b0; in_ready_fell = 1'b0;
        drive_random();
        for (int c = 0; c < 1000 + NB + 20 && received < 1000; c++) begin
            in_valid = (sent < 1000);
            #1;
            if (c >= NB && !out_valid) gaps++;
            cycle(acc);
            if (acc) begin
                sent++;
                drive_random();
            end
        end
        check("tp_received", received, 1000);
        check("tp_gaps", gaps, 0);
        check("tp_in_ready_fell", in_ready_fell, 0);
        check("tp_queue_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
